twiddle_menu_ctrl: RTL
======================

// Module: twiddle_menu_ctrl
// PURPOSE
//  Menu controller for the twiddleboard front panel: turns debounced push-button presses and
//  rotary-encoder step pulses into a two-mode user interface. SELECT mode picks one of NCH
//  channels; EDIT mode adjusts the selected channel's value. It sits between the debounced
//  button/encoder front end and the LED/PWM consumers of the channel values.
// PARAMETERS
//  NCH           3    number of channels (2..4); sel wraps within 0..NCH-1
//  VW            8    channel value width, bits
//  STEP          1    value increment/decrement per encoder step in EDIT mode
//  BLINK_BIT     21   free-running counter bit used for the edit_blink indicator
//  TIMEOUT_BITS  24   inactivity counter width (used only with TIMEOUT_EN)
// PORTS
//  clk        in   1       system clock (16 MHz)
//  rst_n      in   1       asynchronous reset, active low
//  btn_n      in   1       debounced push button, active low (0 = pressed)
//  step_up    in   1       one-cycle pulse, encoder moved +1 detent
//  step_down  in   1       one-cycle pulse, encoder moved -1 detent
//  sel        out  2       currently selected channel
//  edit_mode  out  1       0 = SELECT, 1 = EDIT
//  values     out  NCH*VW  channel values, channel i at [i*VW +: VW]
//  changed    out  1       one-cycle pulse: a value was modified
//  edit_blink out  1       edit_mode AND blink-counter[BLINK_BIT]
// BEHAVIOUR
//  - Reset (async, rst_n=0): sel=0, edit_mode=0, all values=0, changed=0, blink counter=0,
//    press detector primed as released (btn_n history=1). Reset mid-edit discards all state.
//  - Press event = btn_n sampled 1 then 0 on consecutive cycles (falling edge); holding the
//    button generates exactly one event. Release generates nothing.
//  - Event decode per cycle, priority: press > (step_up XOR step_down). step_up and step_down
//    both high in one cycle = no step. A step coincident with a press is dropped.
//  - FSM states: SELECT, EDIT.
//    SELECT: press -> EDIT. step_up: sel = (sel==NCH-1) ? 0 : sel+1.
//            step_down: sel = (sel==0) ? NCH-1 : sel-1. Values untouched.
//    EDIT:   press -> SELECT. step_up: values[sel] += STEP, saturating at 2^VW-1.
//            step_down: values[sel] -= STEP, saturating at 0. sel untouched.
//  - Arithmetic in VW+1 bits, then clamped; no wrap-around of values ever.
//  - changed = 1 in the cycle after a step actually alters a value; a step already at the
//    saturation limit leaves changed=0.
//  - All outputs registered; latency 1 cycle from the event-sampling edge to the output update.
//  - Blink counter is free-running, wraps naturally, not cleared by events.
// CONFIGURATION
//  TWIDDLE_MENU_TIMEOUT_EN defined: an inactivity counter (TIMEOUT_BITS) clears on any press
//    or step and increments otherwise; in EDIT, when it reaches all-ones, the FSM returns to
//    SELECT on the next edge (values kept, changed=0) and the counter clears. A press in the
//    same cycle as expiry takes priority (EDIT->SELECT once, no double toggle).
//  Undefined: no counter is built; edit_mode changes only on press events.
// TESTING
//  1 Reset: rst_n low mid-EDIT with values[0]=5 -> immediately sel=0, edit_mode=0, values=0.
//  2 SELECT wrap: NCH=3, 4x step_up -> sel 1,2,0,1; then 2x step_down -> sel 0,2.
//  3 EDIT saturation: sel=1, press, 3x step_down -> values[1] stays 0, changed never high;
//    260x step_up -> values[1]=255, changed high on the first 255 steps only.
//  4 Conflicts: step_up+step_down together -> no change; press + step_up same cycle ->
//    mode toggles, sel/values unchanged; held button for 1000 cycles -> one toggle only.
//  5 Blink: edit_mode=1 -> edit_blink follows counter bit 21; edit_mode=0 -> edit_blink=0.
//  6 TIMEOUT_EN, TIMEOUT_BITS=4: enter EDIT, idle 15 cycles -> edit_mode=0 next edge;
//    a step at cycle 10 restarts the count.

Source files
------------

// File: rtl/twiddle_menu_ctrl.sv
// Front-panel menu FSM: a button press toggles SELECT/EDIT, and encoder steps move sel or adjust values[sel].
// Outputs update 1 cycle after the sampling edge; there is no backpressure. Optional: TWIDDLE_MENU_TIMEOUT_EN.
module twiddle_menu_ctrl #(
  parameter int NCH          = 3,
  parameter int VW           = 8,
  parameter int STEP         = 1,
  parameter int BLINK_BIT    = 21,
  parameter int TIMEOUT_BITS = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_n,
  input  logic              step_up,
  input  logic              step_down,
  output logic [1:0]        sel,
  output logic              edit_mode,
  output logic [NCH*VW-1:0] values,
  output logic              changed,
  output logic              edit_blink
);

  localparam logic [0:0]  S_SELECT = 1'b0;
  localparam logic [0:0]  S_EDIT   = 1'b1;
  localparam logic [1:0]  SEL_LAST = 2'(NCH - 1);
  localparam logic [VW:0] VMAX     = {1'b0, {VW{1'b1}}};
  localparam logic [VW:0] STEP_W   = (VW + 1)'(STEP);

  logic [0:0]       state, state_nxt;
  logic             btn_q;
  logic             press, up, dn, expire, edit_step;
  logic [VW-1:0]    val_r [NCH];
  logic [VW-1:0]    cur_val, new_val;
  logic [VW:0]      inc_w, dec_w;
  logic [BLINK_BIT:0] blink_cnt;

  // Press wins over steps; opposing steps in the same cycle cancel.
  assign press     = btn_q & ~btn_n;
  assign up        = ~press & step_up & ~step_down;
  assign dn        = ~press & step_down & ~step_up;
  assign edit_step = (state == S_EDIT) & (up | dn);

  always_comb begin
    cur_val = '0;
    for (int i = 0; i < NCH; i++)
      if (sel == 2'(i)) cur_val = val_r[i];
  end

  assign inc_w = {1'b0, cur_val} + STEP_W;
  assign dec_w = {1'b0, cur_val} - STEP_W;

  always_comb begin
    new_val = cur_val;
    if (up)
      new_val = (inc_w > VMAX) ? VMAX[VW-1:0] : inc_w[VW-1:0];
    else if (dn)
      new_val = dec_w[VW] ? '0 : dec_w[VW-1:0];
  end

`ifdef TWIDDLE_MENU_TIMEOUT_EN
  logic [TIMEOUT_BITS-1:0] idle_cnt;
  logic                    activity;

  assign activity = press | step_up | step_down;
  assign expire   = (state == S_EDIT) & (&idle_cnt) & ~activity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if (activity || expire)
      idle_cnt <= '0;
    else
      idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (press)
      state_nxt = ~state;
    else if (expire)
      state_nxt = S_SELECT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_SELECT;
      sel       <= '0;
      btn_q     <= 1'b1;
      changed   <= 1'b0;
      blink_cnt <= '0;
      for (int i = 0; i < NCH; i++) val_r[i] <= '0;
    end else begin
      btn_q     <= btn_n;
      state     <= state_nxt;
      blink_cnt <= blink_cnt + 1'b1;
      changed   <= edit_step && (new_val != cur_val);
      if (state == S_SELECT && up)
        sel <= (sel == SEL_LAST) ? 2'd0 : sel + 2'd1;
      else if (state == S_SELECT && dn)
        sel <= (sel == 2'd0) ? SEL_LAST : sel - 2'd1;
      for (int i = 0; i < NCH; i++)
        if (edit_step && sel == 2'(i)) val_r[i] <= new_val;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign values[g*VW +: VW] = val_r[g];
  end

  assign edit_mode  = state[0];
  assign edit_blink = state[0] & blink_cnt[BLINK_BIT];

endmodule
